pixel_out_framer: RTL

PIXEL_OUT_FRAMER -- requirements
Module: pixel_out_framer

---
 rtl/pixel_out_framer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_out_framer.sv
// Pixel output framer: packs 8-bit filtered pixels into 32-bit words (4 per
// word, first pixel in bits 7:0) and marks line ends and frame start. Words pass
// through a small show-ahead FIFO to a valid/ready sink.
//
// Ports:
//   clk, rst               core clock, synchronous active-high reset
//   start, size_x, size_y  frame start pulse and frame geometry (latched on start)
//   pixel_in, pixel_in_valid  upstream pixel stream, no backpressure
//   word_out, word_valid, word_ready, word_last, word_sof  packed word stream
//   busy, frame_done, overflow  frame status; overflow is sticky until next start
module pixel_out_framer #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] size_x,
    input  logic [11:0] size_y,
    input  logic [7:0]  pixel_in,
    input  logic        pixel_in_valid,
    output logic [31:0] word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        word_last,
    output logic        word_sof,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 34;  // {data[31:0], last, sof}

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t        state;
    logic [11:0]   size_x_r;
    logic [11:0]   size_y_r;
    logic [11:0]   x_cnt;
    logic [11:0]   y_cnt;
    logic [31:0]   asm_word;
    logic          pend_valid;
    logic [EW-1:0] pend_word;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic [CW-1:0] count_next;
    logic [AW-1:0] rd_next;
    logic [EW-1:0] head_next;
    logic          pix_take;
    logic [1:0]    lane;
    logic          x_end;
    logic          y_end;
    logic [31:0]   asm_new;
    logic          word_done;

    // FIFO bookkeeping and next head value for the registered show-ahead output
    always_comb begin
        pop        = word_valid & word_ready;
        full       = (count == CW'(FIFO_DEPTH));
        push_ok    = pend_valid & (~full | pop);
        drop       = pend_valid & ~push_ok;
        count_next = count + CW'(push_ok) - CW'(pop);
        rd_next    = rd_ptr + AW'(pop);
        head_next  = '0;
        if (count_next != '0) begin
            // A word pushed into an otherwise-empty FIFO becomes the head directly
            if ((count - CW'(pop)) == '0) begin
                head_next = pend_word;
            end else begin
                head_next = mem[rd_next];
            end
        end
    end

    // Pixel lane placement and word completion detection
    always_comb begin
        pix_take  = (state == ACTIVE) & pixel_in_valid;
        lane      = x_cnt[1:0];
        x_end     = (x_cnt == 12'(size_x_r - 12'd1));
        y_end     = (y_cnt == 12'(size_y_r - 12'd1));
        // Lane 0 starts a fresh word so unused upper lanes of a partial word stay zero
        asm_new   = ((lane == 2'd0) ? 32'd0 : asm_word)
                    | (32'(pixel_in) << {lane, 3'b000});
        word_done = pix_take & ((lane == 2'd3) | x_end);
    end

    // FIFO storage, no reset needed: occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= pend_word;
        end
    end

    // Frame FSM, word staging, FIFO pointers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            size_x_r   <= '0;
            size_y_r   <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            asm_word   <= '0;
            pend_valid <= 1'b0;
            pend_word  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            word_last  <= 1'b0;
            word_sof   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            rd_ptr     <= rd_next;
            wr_ptr     <= wr_ptr + AW'(push_ok);
            count      <= count_next;
            word_valid <= (count_next != '0);
            {word_out, word_last, word_sof} <= head_next;
            if (drop) begin
                overflow <= 1'b1;
            end
            pend_valid <= word_done;
            pend_word  <= {asm_new, x_end, (y_cnt == 12'd0) && (x_cnt < 12'd4)};

            case (state)
                IDLE: begin
                    if (start) begin
                        if ((size_x != 12'd0) && (size_y != 12'd0)) begin
                            size_x_r <= size_x;
                            size_y_r <= size_y;
                            x_cnt    <= '0;
                            y_cnt    <= '0;
                            asm_word <= '0;
                            overflow <= 1'b0;
                            busy     <= 1'b1;
                            state    <= ACTIVE;
                        end else begin
                            frame_done <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (pix_take) begin
                        asm_word <= word_done ? 32'd0 : asm_new;
                        if (x_end) begin
                            x_cnt <= '0;
                            if (y_end) begin
                                state <= DRAIN;
                            end else begin
                                y_cnt <= y_cnt + 12'd1;
                            end
                        end else begin
                            x_cnt <= x_cnt + 12'd1;
                        end
                    end
                end
                DRAIN: begin
                    // Done once the staged final word has landed and the FIFO empties
                    if (!pend_valid && (count_next == '0)) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
